// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V opcode, ALU select codes and decode bundle for the ID/EX stage
package rv_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;

  // alusrc=1 selects the immediate as ALU operand 2
  typedef struct packed {
    logic [3:0] sel_alu;
    logic       alusrc;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational opcode/funct decode into ALU select and datapath controls
module alu_ctrl_dec
  import rv_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output ctrl_t      o_ctrl
);

  // Unknown opcodes and unsupported funct3 fall through to the illegal default, which keeps SEL_ALU at add
  always_comb begin
    o_ctrl         = '0;
    o_ctrl.illegal = 1'b1;
    case (i_opcode)
      OP_R: begin
        case (i_funct3)
          3'b000:  o_ctrl = '{sel_alu: (i_funct7_5 ? ALU_SUB : ALU_ADD), alusrc: 1'b0, reg_we: 1'b1,
                              mem_rd: 1'b0, mem_wr: 1'b0, illegal: 1'b0};
          3'b110:  o_ctrl = '{sel_alu: ALU_OR,  alusrc: 1'b0, reg_we: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, illegal: 1'b0};
          3'b111:  o_ctrl = '{sel_alu: ALU_AND, alusrc: 1'b0, reg_we: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, illegal: 1'b0};
          default: ;
        endcase
      end
      OP_I: begin
        // funct7[5] is part of the immediate for addi, so it must not select subtract
        case (i_funct3)
          3'b000:  o_ctrl = '{sel_alu: ALU_ADD, alusrc: 1'b1, reg_we: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, illegal: 1'b0};
          3'b110:  o_ctrl = '{sel_alu: ALU_OR,  alusrc: 1'b1, reg_we: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, illegal: 1'b0};
          3'b111:  o_ctrl = '{sel_alu: ALU_AND, alusrc: 1'b1, reg_we: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, illegal: 1'b0};
          default: ;
        endcase
      end
      OP_LOAD:  o_ctrl = '{sel_alu: ALU_ADD, alusrc: 1'b1, reg_we: 1'b1, mem_rd: 1'b1, mem_wr: 1'b0, illegal: 1'b0};
      OP_STORE: o_ctrl = '{sel_alu: ALU_ADD, alusrc: 1'b1, reg_we: 1'b0, mem_rd: 1'b0, mem_wr: 1'b1, illegal: 1'b0};
      default:  ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register feeding the ALU; MEM/WB operand forwarding under ID_EX_FWD_EN
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ID_VALID,
  output logic              ID_READY,
  input  logic [XLEN-1:0]   ID_PC,
  input  logic [XLEN-1:0]   ID_RS1_DATA,
  input  logic [XLEN-1:0]   ID_RS2_DATA,
  input  logic [XLEN-1:0]   ID_IMM,
  input  logic [REG_AW-1:0] ID_RS1_ADDR,
  input  logic [REG_AW-1:0] ID_RS2_ADDR,
  input  logic [REG_AW-1:0] ID_RD_ADDR,
  input  logic [6:0]        ID_OPCODE,
  input  logic [2:0]        ID_FUNCT3,
  input  logic              ID_FUNCT7_5,
  input  logic              FLUSH,
  output logic              EX_VALID,
  input  logic              EX_READY,
  output logic [3:0]        SEL_ALU,
  output logic [XLEN-1:0]   ALU_IN1,
  output logic [XLEN-1:0]   ALU_IN2,
  output logic [XLEN-1:0]   EX_STORE_DATA,
  output logic [XLEN-1:0]   EX_PC,
  output logic [REG_AW-1:0] EX_RD_ADDR,
  output logic              EX_REG_WE,
  output logic              EX_MEM_RD,
  output logic              EX_MEM_WR,
  output logic              EX_ILLEGAL,
  input  logic [REG_AW-1:0] MEM_RD_ADDR,
  input  logic [REG_AW-1:0] WB_RD_ADDR,
  input  logic              MEM_REG_WE,
  input  logic              WB_REG_WE,
  input  logic [XLEN-1:0]   MEM_FWD_DATA,
  input  logic [XLEN-1:0]   WB_FWD_DATA
);

  ctrl_t             w_dec;
  logic              w_load;
  logic [XLEN-1:0]   w_rs1_op;
  logic [XLEN-1:0]   w_rs2_op;

  logic              r_valid;
  ctrl_t             r_ctrl;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1_addr;
  logic [REG_AW-1:0] r_rs2_addr;
  logic [REG_AW-1:0] r_rd_addr;

  alu_ctrl_dec u_dec (
    .i_opcode   (ID_OPCODE),
    .i_funct3   (ID_FUNCT3),
    .i_funct7_5 (ID_FUNCT7_5),
    .o_ctrl     (w_dec)
  );

  assign ID_READY = !r_valid || EX_READY;
  assign w_load   = ID_VALID && ID_READY;

  // Pipeline register: reset beats flush, flush beats load, load beats drain; otherwise hold
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
    end else if (FLUSH) begin
      r_valid        <= 1'b0;
      r_ctrl.reg_we  <= 1'b0;
      r_ctrl.mem_rd  <= 1'b0;
      r_ctrl.mem_wr  <= 1'b0;
      r_ctrl.illegal <= 1'b0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_ctrl     <= w_dec;
      r_pc       <= ID_PC;
      r_rs1_data <= ID_RS1_DATA;
      r_rs2_data <= ID_RS2_DATA;
      r_imm      <= ID_IMM;
      r_rs1_addr <= ID_RS1_ADDR;
      r_rs2_addr <= ID_RS2_ADDR;
      r_rd_addr  <= ID_RD_ADDR;
    end else if (r_valid && EX_READY) begin
      r_valid <= 1'b0;
    end
  end

`ifdef ID_EX_FWD_EN
  // Operand bypass: the younger MEM result wins over WB; x0 is hardwired zero and never bypassed
  always_comb begin
    w_rs1_op = r_rs1_data;
    if (MEM_REG_WE && (MEM_RD_ADDR == r_rs1_addr) && (r_rs1_addr != '0))
      w_rs1_op = MEM_FWD_DATA;
    else if (WB_REG_WE && (WB_RD_ADDR == r_rs1_addr) && (r_rs1_addr != '0))
      w_rs1_op = WB_FWD_DATA;
  end

  // Same bypass for rs2, which feeds both ALU operand 2 and store data
  always_comb begin
    w_rs2_op = r_rs2_data;
    if (MEM_REG_WE && (MEM_RD_ADDR == r_rs2_addr) && (r_rs2_addr != '0))
      w_rs2_op = MEM_FWD_DATA;
    else if (WB_REG_WE && (WB_RD_ADDR == r_rs2_addr) && (r_rs2_addr != '0))
      w_rs2_op = WB_FWD_DATA;
  end
`else
  logic w_fwd_unused;

  assign w_rs1_op     = r_rs1_data;
  assign w_rs2_op     = r_rs2_data;
  // Forwarding sources and captured source indices have no consumer without the bypass
  assign w_fwd_unused = ^{MEM_RD_ADDR, WB_RD_ADDR, MEM_REG_WE, WB_REG_WE, MEM_FWD_DATA, WB_FWD_DATA,
                          r_rs1_addr, r_rs2_addr};
`endif

  assign EX_VALID      = r_valid;
  assign SEL_ALU       = r_ctrl.sel_alu;
  assign ALU_IN1       = w_rs1_op;
  assign ALU_IN2       = r_ctrl.alusrc ? r_imm : w_rs2_op;
  assign EX_STORE_DATA = w_rs2_op;
  assign EX_PC         = r_pc;
  assign EX_RD_ADDR    = r_rd_addr;
  assign EX_REG_WE     = r_ctrl.reg_we;
  assign EX_MEM_RD     = r_ctrl.mem_rd;
  assign EX_MEM_WR     = r_ctrl.mem_wr;
  assign EX_ILLEGAL    = r_ctrl.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage with randomized reference-model run
module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RST_N, ID_VALID, ID_READY, FLUSH, EX_VALID, EX_READY;
  logic [31:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR;
  logic [6:0]  ID_OPCODE;
  logic [2:0]  ID_FUNCT3;
  logic        ID_FUNCT7_5;
  logic [3:0]  SEL_ALU;
  logic [31:0] ALU_IN1, ALU_IN2, EX_STORE_DATA, EX_PC;
  logic [4:0]  EX_RD_ADDR;
  logic        EX_REG_WE, EX_MEM_RD, EX_MEM_WR, EX_ILLEGAL;
  logic [4:0]  MEM_RD_ADDR, WB_RD_ADDR;
  logic        MEM_REG_WE, WB_REG_WE;
  logic [31:0] MEM_FWD_DATA, WB_FWD_DATA;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  id_ex_stage dut (
    .CLK(CLK), .RST_N(RST_N), .ID_VALID(ID_VALID), .ID_READY(ID_READY), .ID_PC(ID_PC),
    .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR), .ID_RD_ADDR(ID_RD_ADDR),
    .ID_OPCODE(ID_OPCODE), .ID_FUNCT3(ID_FUNCT3), .ID_FUNCT7_5(ID_FUNCT7_5), .FLUSH(FLUSH),
    .EX_VALID(EX_VALID), .EX_READY(EX_READY), .SEL_ALU(SEL_ALU), .ALU_IN1(ALU_IN1), .ALU_IN2(ALU_IN2),
    .EX_STORE_DATA(EX_STORE_DATA), .EX_PC(EX_PC), .EX_RD_ADDR(EX_RD_ADDR), .EX_REG_WE(EX_REG_WE),
    .EX_MEM_RD(EX_MEM_RD), .EX_MEM_WR(EX_MEM_WR), .EX_ILLEGAL(EX_ILLEGAL),
    .MEM_RD_ADDR(MEM_RD_ADDR), .WB_RD_ADDR(WB_RD_ADDR), .MEM_REG_WE(MEM_REG_WE), .WB_REG_WE(WB_REG_WE),
    .MEM_FWD_DATA(MEM_FWD_DATA), .WB_FWD_DATA(WB_FWD_DATA)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic [4:0] a1, input logic [31:0] d1, input logic [4:0] a2,
                           input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] rd,
                           input logic [31:0] pc);
    ID_OPCODE = op; ID_FUNCT3 = f3; ID_FUNCT7_5 = f75;
    ID_RS1_ADDR = a1; ID_RS1_DATA = d1; ID_RS2_ADDR = a2; ID_RS2_DATA = d2;
    ID_IMM = imm; ID_RD_ADDR = rd; ID_PC = pc;
  endtask

  task automatic clear_fwd();
    MEM_RD_ADDR = '0; WB_RD_ADDR = '0; MEM_REG_WE = 1'b0; WB_REG_WE = 1'b0;
    MEM_FWD_DATA = '0; WB_FWD_DATA = '0;
  endtask

  // Reference decode straight from the instruction table: {sel[3:0], imm_src, reg_we, mem_rd, mem_wr, illegal}
  function automatic logic [8:0] exp_dec(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    if (op == 7'b0110011 && f3 == 3'b000) return {f75, 3'b000, 5'b01000};
    if (op == 7'b0110011 && f3 == 3'b110) return {4'b0110, 5'b01000};
    if (op == 7'b0110011 && f3 == 3'b111) return {4'b0111, 5'b01000};
    if (op == 7'b0010011 && f3 == 3'b000) return {4'b0000, 5'b11000};
    if (op == 7'b0010011 && f3 == 3'b110) return {4'b0110, 5'b11000};
    if (op == 7'b0010011 && f3 == 3'b111) return {4'b0111, 5'b11000};
    if (op == 7'b0000011) return {4'b0000, 5'b11100};
    if (op == 7'b0100011) return {4'b0000, 5'b10010};
    return {4'b0000, 5'b00001};
  endfunction

  // Reference operand value as seen by EX given the current MEM/WB state
  function automatic logic [31:0] exp_op(input logic [4:0] a, input logic [31:0] regv);
`ifdef ID_EX_FWD_EN
    if (a != 0 && MEM_REG_WE && MEM_RD_ADDR == a) return MEM_FWD_DATA;
    if (a != 0 && WB_REG_WE && WB_RD_ADDR == a) return WB_FWD_DATA;
`endif
    return regv;
  endfunction

  task automatic test_reset();
    RST_N = 1'b0; FLUSH = 1'b1; ID_VALID = 1'b1; EX_READY = 1'b0; clear_fwd();
    set_instr(7'b0110011, 3'b000, 1'b1, 5'd3, 32'hDEAD, 5'd4, 32'hBEEF, 32'h55, 5'd9, 32'h100);
    tick(); tick();
    FLUSH = 1'b0;
    n_checks++;
    if ({EX_VALID, SEL_ALU, ALU_IN1, ALU_IN2, EX_STORE_DATA, EX_PC, EX_RD_ADDR,
         EX_REG_WE, EX_MEM_RD, EX_MEM_WR, EX_ILLEGAL} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: valid=%b sel=%h in1=%h in2=%h pc=%h required all zero",
                         EX_VALID, SEL_ALU, ALU_IN1, ALU_IN2, EX_PC);
    end
    n_checks++;
    if (ID_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", ID_READY); end
    RST_N = 1'b1; ID_VALID = 1'b0; EX_READY = 1'b1;
    tick();
  endtask

  task automatic test_r_sub();
    set_instr(7'b0110011, 3'b000, 1'b1, 5'd1, 32'd10, 5'd2, 32'd3, 32'h7FF, 5'd7, 32'h200);
    ID_VALID = 1'b1; EX_READY = 1'b1;
    tick();
    ID_VALID = 1'b0;
    n_checks++;
    if ({EX_VALID, SEL_ALU, ALU_IN1, ALU_IN2, EX_REG_WE, EX_PC, EX_RD_ADDR} !==
        {1'b1, 4'b1000, 32'd10, 32'd3, 1'b1, 32'h200, 5'd7}) begin
      n_fail++; $display("FAIL r_sub: valid=%b sel=%b in1=%0d in2=%0d we=%b pc=%h rd=%0d required 1 1000 10 3 1 200 7",
                         EX_VALID, SEL_ALU, ALU_IN1, ALU_IN2, EX_REG_WE, EX_PC, EX_RD_ADDR);
    end
    tick();
    n_checks++;
    if (EX_VALID !== 1'b0) begin n_fail++; $display("FAIL r_sub_drain: valid=%b required 0", EX_VALID); end
  endtask

  task automatic test_backpressure();
    set_instr(7'b0110011, 3'b000, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd3, 32'h300);
    ID_VALID = 1'b1; EX_READY = 1'b0;
    tick();
    set_instr(7'b0110011, 3'b111, 1'b0, 5'd4, 32'd7, 5'd5, 32'd9, 32'd0, 5'd6, 32'h304);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ID_READY !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b required 0", i, ID_READY); end
      n_checks++;
      if ({EX_VALID, SEL_ALU, ALU_IN1, ALU_IN2, EX_PC} !== {1'b1, 4'b0000, 32'd1, 32'd2, 32'h300}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid=%b sel=%b in1=%0d in2=%0d pc=%h required 1 0000 1 2 300",
                           i, EX_VALID, SEL_ALU, ALU_IN1, ALU_IN2, EX_PC);
      end
      tick();
    end
    EX_READY = 1'b1;
    #1;
    n_checks++;
    if (ID_READY !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b required 1", ID_READY); end
    tick();
    ID_VALID = 1'b0;
    n_checks++;
    if ({EX_VALID, SEL_ALU, ALU_IN1, ALU_IN2, EX_PC} !== {1'b1, 4'b0111, 32'd7, 32'd9, 32'h304}) begin
      n_fail++; $display("FAIL bp_next: valid=%b sel=%b in1=%0d in2=%0d pc=%h required 1 0111 7 9 304",
                         EX_VALID, SEL_ALU, ALU_IN1, ALU_IN2, EX_PC);
    end
    tick();
  endtask

  task automatic test_flush_reset();
    set_instr(7'b0000011, 3'b010, 1'b0, 5'd1, 32'h40, 5'd2, 32'h41, 32'h8, 5'd5, 32'h400);
    ID_VALID = 1'b1; EX_READY = 1'b1; FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    n_checks++;
    if ({EX_VALID, EX_REG_WE, EX_MEM_RD, EX_MEM_WR, EX_ILLEGAL} !== 5'b0) begin
      n_fail++; $display("FAIL flush: valid=%b we=%b rd=%b wr=%b ill=%b required all 0",
                         EX_VALID, EX_REG_WE, EX_MEM_RD, EX_MEM_WR, EX_ILLEGAL);
    end
    EX_READY = 1'b0;
    tick();
    n_checks++;
    if ({EX_VALID, EX_MEM_RD, ALU_IN2} !== {1'b1, 1'b1, 32'h8}) begin
      n_fail++; $display("FAIL load_decode: valid=%b mem_rd=%b in2=%h required 1 1 8", EX_VALID, EX_MEM_RD, ALU_IN2);
    end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1; ID_VALID = 1'b0; EX_READY = 1'b1;
    n_checks++;
    if ({EX_VALID, SEL_ALU, ALU_IN1, ALU_IN2, EX_STORE_DATA, EX_PC, EX_RD_ADDR,
         EX_REG_WE, EX_MEM_RD, EX_MEM_WR, EX_ILLEGAL} !== '0) begin
      n_fail++; $display("FAIL reset_mid_hold: valid=%b in1=%h in2=%h pc=%h mem_rd=%b required all zero",
                         EX_VALID, ALU_IN1, ALU_IN2, EX_PC, EX_MEM_RD);
    end
  endtask

  task automatic test_illegal_ori();
    set_instr(7'b1110011, 3'b000, 1'b1, 5'd1, 32'h11, 5'd2, 32'h22, 32'h33, 5'd4, 32'h500);
    ID_VALID = 1'b1; EX_READY = 1'b1;
    tick();
    n_checks++;
    if ({EX_VALID, EX_ILLEGAL, SEL_ALU, EX_REG_WE, EX_MEM_RD, EX_MEM_WR} !== {1'b1, 1'b1, 4'b0000, 3'b000}) begin
      n_fail++; $display("FAIL illegal: valid=%b ill=%b sel=%b we=%b required 1 1 0000 0",
                         EX_VALID, EX_ILLEGAL, SEL_ALU, EX_REG_WE);
    end
    set_instr(7'b0010011, 3'b110, 1'b1, 5'd1, 32'h0F, 5'd2, 32'h22, 32'hF0, 5'd4, 32'h504);
    tick();
    n_checks++;
    if ({SEL_ALU, ALU_IN1, ALU_IN2, EX_REG_WE, EX_ILLEGAL} !== {4'b0110, 32'h0F, 32'hF0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL ori: sel=%b in1=%h in2=%h we=%b ill=%b required 0110 0f f0 1 0",
                         SEL_ALU, ALU_IN1, ALU_IN2, EX_REG_WE, EX_ILLEGAL);
    end
    set_instr(7'b0100011, 3'b010, 1'b0, 5'd1, 32'h1000, 5'd2, 32'hCAFE, 32'h4, 5'd0, 32'h508);
    tick();
    ID_VALID = 1'b0;
    n_checks++;
    if ({EX_MEM_WR, EX_REG_WE, ALU_IN2, EX_STORE_DATA} !== {1'b1, 1'b0, 32'h4, 32'hCAFE}) begin
      n_fail++; $display("FAIL store: wr=%b we=%b in2=%h sdata=%h required 1 0 4 cafe",
                         EX_MEM_WR, EX_REG_WE, ALU_IN2, EX_STORE_DATA);
    end
    tick();
  endtask

  task automatic test_forwarding();
    logic [31:0] want;
    set_instr(7'b0100011, 3'b010, 1'b0, 5'd5, 32'h11, 5'd6, 32'h22, 32'h0, 5'd0, 32'h600);
    ID_VALID = 1'b1; EX_READY = 1'b0;
    tick();
    ID_VALID = 1'b0;
    MEM_RD_ADDR = 5'd5; MEM_REG_WE = 1'b1; MEM_FWD_DATA = 32'hAA;
    WB_RD_ADDR = 5'd5; WB_REG_WE = 1'b1; WB_FWD_DATA = 32'hBB;
    #1;
`ifdef ID_EX_FWD_EN
    want = 32'hAA;
`else
    want = 32'h11;
`endif
    n_checks++;
    if (ALU_IN1 !== want) begin n_fail++; $display("FAIL fwd_mem_over_wb: in1=%h required %h", ALU_IN1, want); end
    MEM_REG_WE = 1'b0; #1;
`ifdef ID_EX_FWD_EN
    want = 32'hBB;
`else
    want = 32'h11;
`endif
    n_checks++;
    if (ALU_IN1 !== want) begin n_fail++; $display("FAIL fwd_wb: in1=%h required %h", ALU_IN1, want); end
    MEM_RD_ADDR = 5'd6; MEM_REG_WE = 1'b1; MEM_FWD_DATA = 32'hCC; #1;
`ifdef ID_EX_FWD_EN
    want = 32'hCC;
`else
    want = 32'h22;
`endif
    n_checks++;
    if (EX_STORE_DATA !== want) begin n_fail++; $display("FAIL fwd_store: sdata=%h required %h", EX_STORE_DATA, want); end
    EX_READY = 1'b1; clear_fwd();
    set_instr(7'b0110011, 3'b000, 1'b0, 5'd0, 32'h0, 5'd6, 32'h22, 32'h0, 5'd1, 32'h604);
    ID_VALID = 1'b1;
    tick();
    ID_VALID = 1'b0;
    MEM_RD_ADDR = 5'd0; MEM_REG_WE = 1'b1; MEM_FWD_DATA = 32'hAA;
    WB_RD_ADDR = 5'd0; WB_REG_WE = 1'b1; WB_FWD_DATA = 32'hBB;
    #1;
    n_checks++;
    if (ALU_IN1 !== 32'h0) begin n_fail++; $display("FAIL fwd_x0: in1=%h required 0", ALU_IN1); end
    clear_fwd();
    tick();
  endtask

  task automatic test_random();
    logic        mv, kc, kd, rdy;
    logic [8:0]  mc;
    logic [31:0] mpc, m1, m2, mimm;
    logic [4:0]  ma1, ma2, mrd;
    logic [6:0]  ops [6];
    logic [31:0] e_in2;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1110011; ops[5] = 7'b1100011;
    RST_N = 1'b0; FLUSH = 1'b0; ID_VALID = 1'b0; clear_fwd();
    tick();
    mv = 0; mc = '0; mpc = '0; m1 = '0; m2 = '0; mimm = '0; ma1 = '0; ma2 = '0; mrd = '0; kc = 1; kd = 1;
    for (int i = 0; i < 400; i++) begin
      RST_N    = ($urandom_range(0, 39) != 0);
      FLUSH    = ($urandom_range(0, 7) == 0);
      ID_VALID = ($urandom_range(0, 9) < 7);
      EX_READY = ($urandom_range(0, 9) < 6);
      set_instr(ops[$urandom_range(0, 5)], 3'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                5'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom), $urandom);
      MEM_REG_WE = 1'($urandom); WB_REG_WE = 1'($urandom);
      MEM_RD_ADDR = 5'($urandom_range(0, 3)); WB_RD_ADDR = 5'($urandom_range(0, 3));
      MEM_FWD_DATA = $urandom; WB_FWD_DATA = $urandom;
      #1;
      rdy = !mv || EX_READY;
      n_checks++;
      if (ID_READY !== rdy) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b required %b", i, ID_READY, rdy); end
      if (!RST_N) begin
        mv = 0; mc = '0; mpc = '0; m1 = '0; m2 = '0; mimm = '0; ma1 = '0; ma2 = '0; mrd = '0; kc = 1; kd = 1;
      end else if (FLUSH) begin
        mv = 0; mc[3:0] = 4'b0; kc = 1; kd = 0;
      end else if (ID_VALID && rdy) begin
        mv = 1; mc = exp_dec(ID_OPCODE, ID_FUNCT3, ID_FUNCT7_5);
        mpc = ID_PC; m1 = ID_RS1_DATA; m2 = ID_RS2_DATA; mimm = ID_IMM;
        ma1 = ID_RS1_ADDR; ma2 = ID_RS2_ADDR; mrd = ID_RD_ADDR; kc = 0; kd = 0;
      end else if (mv && EX_READY) begin
        mv = 0;
      end
      tick();
      n_checks++;
      if (EX_VALID !== mv) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b required %b", i, EX_VALID, mv); end
      if (mv || kc) begin
        n_checks++;
        if ({EX_REG_WE, EX_MEM_RD, EX_MEM_WR, EX_ILLEGAL} !== mc[3:0]) begin
          n_fail++; $display("FAIL rand_ctrl[%0d]: got %b required %b", i,
                             {EX_REG_WE, EX_MEM_RD, EX_MEM_WR, EX_ILLEGAL}, mc[3:0]);
        end
      end
      if (mv || kd) begin
        e_in2 = mc[4] ? mimm : exp_op(ma2, m2);
        n_checks++;
        if ({SEL_ALU, ALU_IN1, ALU_IN2, EX_STORE_DATA, EX_PC, EX_RD_ADDR} !==
            {mc[8:5], exp_op(ma1, m1), e_in2, exp_op(ma2, m2), mpc, mrd}) begin
          n_fail++; $display("FAIL rand_data[%0d]: sel=%b in1=%h in2=%h sd=%h pc=%h rd=%0d required %b %h %h %h %h %0d",
                             i, SEL_ALU, ALU_IN1, ALU_IN2, EX_STORE_DATA, EX_PC, EX_RD_ADDR,
                             mc[8:5], exp_op(ma1, m1), e_in2, exp_op(ma2, m2), mpc, mrd);
        end
      end
    end
    RST_N = 1'b1; FLUSH = 1'b0; ID_VALID = 1'b0;
  endtask

  initial begin
    test_reset();
    test_r_sub();
    test_backpressure();
    test_flush_reset();
    test_illegal_ori();
    test_forwarding();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
